// File: rtl/tube_pkg.sv
// Shared definitions for the seven-segment tube display controller:
// register offsets, CTRL bit positions, scan FSM states, the shadow
// frame record and the hex-to-segment lookup table.
package tube_pkg;

  localparam logic [31:0] TUBE_DATA_OFS = 32'd0;
  localparam logic [31:0] TUBE_CTRL_OFS = 32'd4;

  localparam int CTRL_EN_BIT = 0;
  localparam int CTRL_DP_LSB = 4;
  localparam int CTRL_DP_MSB = 7;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } tube_state_t;

  // Frame-aligned copy of what is on the tubes: dp[k] and nibble k belong to digit k.
  typedef struct packed {
    logic [3:0]  dp;
    logic [15:0] data;
  } tube_shadow_t;

  // Segment patterns g..a for hex 0..F; element 0 is the pattern for '0'.
  localparam logic [0:15][6:0] SEG7_TABLE = {
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/tube_display_ctrl_if.sv
// CPU data-memory bus slice seen by the tube display peripheral.
interface tube_display_ctrl_if;

  // Bus protocol: there is no valid/ready pair. MemWrite is a one-cycle
  // store strobe sampled on the sysclk edge together with MemBus_Address and
  // MemBus_Write_Data; the slave always accepts. MemRead qualifies a load and
  // Device_Read_Data answers combinationally in the same cycle, 0 when the
  // address does not hit a register or MemRead is low.
  logic [31:0] MemBus_Address;
  logic [31:0] MemBus_Write_Data;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] Device_Read_Data;

  modport master (
    output MemBus_Address,
    output MemBus_Write_Data,
    output MemWrite,
    output MemRead,
    input  Device_Read_Data
  );

  modport slave (
    input  MemBus_Address,
    input  MemBus_Write_Data,
    input  MemWrite,
    input  MemRead,
    output Device_Read_Data
  );

endinterface

// File: rtl/seg7_decoder.sv
// Combinational hex nibble to seven-segment (g..a) decoder with a blank input.
module seg7_decoder
  import tube_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  // Table lookup, forced dark when blanked.
  always_comb begin
    seg = blank ? 7'h00 : SEG7_TABLE[nibble];
  end

endmodule

// File: rtl/tube_display_ctrl.sv
// Memory-mapped 4-digit seven-segment display controller.
// DATA at BASE_ADDR, CTRL at BASE_ADDR+4 (EN = bit0, DP for digits 3..0 = bits 7:4).
// Each digit is lit for SCAN_DIV cycles; the value shown is a shadow copy
// refreshed only at frame boundaries so a frame never mixes two values.
// Optional build macro TUBE_LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module tube_display_ctrl
  import tube_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0010,
  parameter int          SCAN_DIV  = 100_000
) (
  input  logic                sysclk,
  input  logic                reset,
  tube_display_ctrl_if.slave  bus,
  output logic [3:0]          tube_select,
  output logic [7:0]          tube_segment,
  output tube_state_t         dbg_state
);

  localparam int                DIV_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [15:0]      data_r;
  logic [7:0]       ctrl_r;
  logic             hit_data;
  logic             hit_ctrl;
  logic             en;

  tube_state_t      state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       digit_q, digit_d;
  tube_shadow_t     shadow_q, shadow_d;
  tube_shadow_t     live_frame;

  logic [3:0]       cur_nibble;
  logic             cur_blank;
  logic [6:0]       cur_seg;
  logic             unused_wdata;

  assign hit_data     = (bus.MemBus_Address == BASE_ADDR + TUBE_DATA_OFS);
  assign hit_ctrl     = (bus.MemBus_Address == BASE_ADDR + TUBE_CTRL_OFS);
  assign en           = ctrl_r[CTRL_EN_BIT];
  assign live_frame   = '{dp: ctrl_r[CTRL_DP_MSB:CTRL_DP_LSB], data: data_r};
  assign dbg_state    = state_q;
  assign unused_wdata = ^{bus.MemBus_Write_Data[31:16], bus.MemBus_Write_Data[3:1]};

  // CPU-visible registers; reserved CTRL bits are stored as zero.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      data_r <= 16'h0;
      ctrl_r <= 8'h00;
    end else if (bus.MemWrite) begin
      if (hit_data) data_r <= bus.MemBus_Write_Data[15:0];
      if (hit_ctrl) ctrl_r <= {bus.MemBus_Write_Data[7:4], 3'b000, bus.MemBus_Write_Data[0]};
    end
  end

  // Side-effect-free load path, zero unless a register is addressed.
  always_comb begin
    bus.Device_Read_Data = 32'h0;
    if (bus.MemRead && hit_data) bus.Device_Read_Data = {16'h0, data_r};
    else if (bus.MemRead && hit_ctrl) bus.Device_Read_Data = {24'h0, ctrl_r};
  end

  // Scan state, divider, digit index and shadow frame registers.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      div_q    <= '0;
      digit_q  <= 2'd0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      digit_q  <= digit_d;
      shadow_q <= shadow_d;
    end
  end

  // Scan sequencing: start a frame on EN, advance digits every SCAN_DIV
  // cycles, reload the shadow only when digit 3 hands back to digit 0.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    digit_d  = digit_q;
    shadow_d = shadow_q;
    case (state_q)
      IDLE: begin
        div_d   = '0;
        digit_d = 2'd0;
        if (en) begin
          state_d  = SCAN;
          shadow_d = live_frame;
        end
      end
      SCAN: begin
        if (!en) begin
          state_d = IDLE;
          div_d   = '0;
          digit_d = 2'd0;
        end else if (div_q == DIV_LAST) begin
          div_d   = '0;
          digit_d = digit_q + 2'd1;
          if (digit_q == 2'd3) shadow_d = live_frame;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cur_nibble = shadow_q.data[{digit_q, 2'b00} +: 4];

`ifdef TUBE_LEADING_ZERO_BLANK_EN
  // A digit above 0 is blank when it and every higher nibble are zero.
  always_comb begin
    cur_blank = 1'b0;
    case (digit_q)
      2'd1:    cur_blank = (shadow_q.data[15:4]  == 12'h0);
      2'd2:    cur_blank = (shadow_q.data[15:8]  == 8'h0);
      2'd3:    cur_blank = (shadow_q.data[15:12] == 4'h0);
      default: cur_blank = 1'b0;
    endcase
  end
`else
  // Leading zeros are shown like any other digit.
  always_comb begin
    cur_blank = 1'b0;
  end
`endif

  seg7_decoder u_seg7_decoder (
    .nibble (cur_nibble),
    .blank  (cur_blank),
    .seg    (cur_seg)
  );

  // Registered tube drive, dark whenever the scanner is idle.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      tube_select  <= 4'b0000;
      tube_segment <= 8'h00;
    end else if (state_q == SCAN) begin
      tube_select  <= 4'b0001 << digit_q;
      tube_segment <= {shadow_q.dp[digit_q], cur_seg};
    end else begin
      tube_select  <= 4'b0000;
      tube_segment <= 8'h00;
    end
  end

endmodule
